// File: rtl/alu_tx_pkg.sv
// Shared types and ASCII helpers for the ALU result hex transmitter.
package alu_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HEX,
      ERR,
      CR,
      LF
   } tx_state_e;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_E  = 8'h45;
   localparam logic [7:0] ASCII_R  = 8'h52;

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic uppercase);
      if (nibble < 4'd10) begin
         return 8'h30 + {4'h0, nibble};
      end else if (uppercase) begin
         return 8'h37 + {4'h0, nibble};
      end else begin
         return 8'h57 + {4'h0, nibble};
      end
   endfunction

endpackage

// File: rtl/alu_hex_tx.sv
// Serialises one ALU result word per handshake into an AXI-stream packet of
// ASCII hex digits (MS nibble first), or "ERR", optionally followed by CR LF.
//
// state | meaning
// IDLE  | s_ready_o high, waiting for a result word
// HEX   | presenting hex digit at nibble index idx_q
// ERR   | presenting "ERR", idx_q counts remaining characters
// CR    | presenting carriage return
// LF    | presenting line feed (always the last byte when present)
module alu_hex_tx
   import alu_tx_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter bit INCLUDE_CRLF = 1'b1,
   parameter bit UPPERCASE    = 1'b1,
   parameter int AXI_WIDTH    = 8
) (
   input  logic                  aclk_i,
   input  logic                  arst_ni,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_err_i,
   output logic                  m_axis_tvalid_o,
   output logic [7:0]            m_axis_tdata_o,
   output logic                  m_axis_tlast_o,
   output logic [11:0]           m_axis_tuser_o,
   input  logic                  m_axis_tready_i
);

   localparam int N     = DATA_WIDTH / 4;
   localparam int IDX_W = 4;
   localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] ERR_IDX  = IDX_W'(2);

   if (AXI_WIDTH != 8) begin : g_bad_axi_width
      $error("alu_hex_tx: AXI_WIDTH must be 8");
   end
   if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4 || DATA_WIDTH > 64) begin : g_bad_data_width
      $error("alu_hex_tx: DATA_WIDTH must be a multiple of 4 in 4..64");
   end

   tx_state_e             state_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [IDX_W-1:0]      idx_q;
   logic [11:0]           seq_q;

   logic [IDX_W-1:0] idx_dec;
   logic [5:0]       shamt;
   logic [3:0]       next_nib;
   logic             accept;

   assign accept   = m_axis_tvalid_o && m_axis_tready_i;
   assign idx_dec  = idx_q - IDX_W'(1);
   assign shamt    = {idx_dec, 2'b00};
   assign next_nib = 4'(data_q >> shamt);

   always_ff @(posedge aclk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q         <= IDLE;
         data_q          <= '0;
         idx_q           <= '0;
         seq_q           <= '0;
         s_ready_o       <= 1'b1;
         m_axis_tvalid_o <= 1'b0;
         m_axis_tdata_o  <= '0;
         m_axis_tlast_o  <= 1'b0;
         m_axis_tuser_o  <= '0;
      end else if (accept && m_axis_tlast_o) begin
         // packet complete: one bubble cycle in IDLE before the next word
         state_q         <= IDLE;
         s_ready_o       <= 1'b1;
         m_axis_tvalid_o <= 1'b0;
         m_axis_tlast_o  <= 1'b0;
         seq_q           <= seq_q + 12'd1;
      end else begin
         case (state_q)
            IDLE: begin
               if (s_valid_i && s_ready_o) begin
                  data_q          <= s_data_i;
                  s_ready_o       <= 1'b0;
                  m_axis_tvalid_o <= 1'b1;
                  m_axis_tuser_o  <= seq_q;
                  if (s_err_i) begin
                     state_q        <= ERR;
                     idx_q          <= ERR_IDX;
                     m_axis_tdata_o <= ASCII_E;
                     m_axis_tlast_o <= 1'b0;
                  end else begin
                     state_q        <= HEX;
                     idx_q          <= TOP_IDX;
                     m_axis_tdata_o <= nibble_to_ascii(s_data_i[DATA_WIDTH-1 -: 4], UPPERCASE);
                     m_axis_tlast_o <= (N == 1) && !INCLUDE_CRLF;
                  end
               end
            end
            HEX, ERR: begin
               if (accept) begin
                  if (idx_q != '0) begin
                     idx_q          <= idx_dec;
                     m_axis_tdata_o <= (state_q == ERR) ? ASCII_R
                                                        : nibble_to_ascii(next_nib, UPPERCASE);
                     m_axis_tlast_o <= (idx_dec == '0) && !INCLUDE_CRLF;
                  end else begin
                     state_q        <= CR;
                     m_axis_tdata_o <= ASCII_CR;
                     m_axis_tlast_o <= 1'b0;
                  end
               end
            end
            CR: begin
               if (accept) begin
                  state_q        <= LF;
                  m_axis_tdata_o <= ASCII_LF;
                  m_axis_tlast_o <= 1'b1;
               end
            end
            LF: begin
               state_q <= LF;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_hex_tx.sv
// Randomised self-checking bench for alu_hex_tx against a byte-list reference model.
module tb_alu_hex_tx;

   logic              clk;
   logic              arst_n;
   logic [2:0]        s_valid;
   logic [2:0]        s_ready;
   logic [15:0]       s_data;
   logic              s_err;
   logic [2:0]        tvalid;
   logic [2:0][7:0]   tdata;
   logic [2:0]        tlast;
   logic [2:0][11:0]  tuser;
   logic              tready;

   int errors = 0;
   int checks = 0;
   int seq_exp[3] = '{0, 0, 0};

   alu_hex_tx dut0 (
      .aclk_i(clk), .arst_ni(arst_n), .s_valid_i(s_valid[0]), .s_ready_o(s_ready[0]),
      .s_data_i(s_data), .s_err_i(s_err), .m_axis_tvalid_o(tvalid[0]),
      .m_axis_tdata_o(tdata[0]), .m_axis_tlast_o(tlast[0]), .m_axis_tuser_o(tuser[0]),
      .m_axis_tready_i(tready)
   );

   alu_hex_tx #(.UPPERCASE(1'b0)) dut1 (
      .aclk_i(clk), .arst_ni(arst_n), .s_valid_i(s_valid[1]), .s_ready_o(s_ready[1]),
      .s_data_i(s_data), .s_err_i(s_err), .m_axis_tvalid_o(tvalid[1]),
      .m_axis_tdata_o(tdata[1]), .m_axis_tlast_o(tlast[1]), .m_axis_tuser_o(tuser[1]),
      .m_axis_tready_i(tready)
   );

   alu_hex_tx #(.INCLUDE_CRLF(1'b0)) dut2 (
      .aclk_i(clk), .arst_ni(arst_n), .s_valid_i(s_valid[2]), .s_ready_o(s_ready[2]),
      .s_data_i(s_data), .s_err_i(s_err), .m_axis_tvalid_o(tvalid[2]),
      .m_axis_tdata_o(tdata[2]), .m_axis_tlast_o(tlast[2]), .m_axis_tuser_o(tuser[2]),
      .m_axis_tready_i(tready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected byte list of one packet, straight from the character rules.
   task automatic model(input logic [15:0] w, input bit err, input bit uc, input bit crlf,
                        output logic [7:0] q[$]);
      int d;
      q = {};
      if (err) begin
         q.push_back(8'h45); q.push_back(8'h52); q.push_back(8'h52);
      end else begin
         for (int i = 3; i >= 0; i--) begin
            d = (int'(w) >> (4 * i)) % 16;
            if (d < 10) q.push_back(8'(48 + d));
            else if (uc) q.push_back(8'(65 + d - 10));
            else q.push_back(8'(97 + d - 10));
         end
      end
      if (crlf) begin
         q.push_back(8'h0D); q.push_back(8'h0A);
      end
   endtask

   // Drives one word into DUT sel and records every accepted byte plus protocol anomalies.
   task automatic drive_packet(input int sel, input logic [15:0] w, input bit err, input bit rnd_ready,
                               output logic [7:0] bq[$], output bit lq[$], output logic [11:0] uq[$],
                               output int lat, output int anom);
      int cyc;
      bit done, stalled;
      logic [7:0] hd; logic hl; logic [11:0] hu;
      bq = {}; lq = {}; uq = {};
      anom = 0; lat = 0; cyc = 0; done = 0; stalled = 0;
      hd = '0; hl = 1'b0; hu = '0;
      s_data = w; s_err = err; tready = 1'b1;
      while (!s_ready[sel] && cyc < 100) begin @(negedge clk); cyc++; end
      s_valid[sel] = 1'b1;
      @(negedge clk);
      s_valid[sel] = 1'b0;
      tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!tvalid[sel] && lat < 20) begin @(negedge clk); lat++; end
      cyc = 0;
      while (!done && cyc < 300) begin
         if (!tvalid[sel] || s_ready[sel]) anom++;
         if (stalled && (tdata[sel] !== hd || tlast[sel] !== hl || tuser[sel] !== hu)) anom++;
         if (tready) begin
            bq.push_back(tdata[sel]); lq.push_back(tlast[sel]); uq.push_back(tuser[sel]);
            done = tlast[sel]; stalled = 0;
         end else begin
            stalled = 1; hd = tdata[sel]; hl = tlast[sel]; hu = tuser[sel];
         end
         @(negedge clk);
         cyc++;
         tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (!done) anom++;
      tready = 1'b1;
   endtask

   task automatic test_reset();
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (tvalid[s] !== 1'b0 || tdata[s] !== 8'h00 || tlast[s] !== 1'b0 || tuser[s] !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs dut%0d got v=%b d=%h l=%b u=%h want 0/00/0/000", s, tvalid[s], tdata[s], tlast[s], tuser[s]);
         end
         checks++;
         if (s_ready[s] !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready dut%0d got %b want 1", s, s_ready[s]);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp[$]; logic [7:0] bq[$]; bit lq[$]; logic [11:0] uq[$];
      logic [15:0] w; bit e; int lat, anom;
      for (int n = 0; n < 8; n++) begin
         w = (n == 0) ? 16'h1A2F : (n == 1) ? 16'h1234 : 16'($urandom);
         e = (n == 1) ? 1'b1 : (n == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
         drive_packet(0, w, e, 1'b0, bq, lq, uq, lat, anom);
         model(w, e, 1'b1, 1'b1, exp);
         checks++;
         if (bq.size() != exp.size()) begin
            errors++; $display("FAIL basic_len w=%h err=%b got %0d want %0d", w, e, bq.size(), exp.size());
         end
         for (int i = 0; i < exp.size() && i < bq.size(); i++) begin
            checks++;
            if (bq[i] !== exp[i] || lq[i] !== (i == exp.size() - 1) || uq[i] !== 12'(seq_exp[0])) begin
               errors++;
               $display("FAIL basic_byte[%0d] w=%h got %h/%b/%0d want %h/%b/%0d", i, w, bq[i], lq[i], uq[i],
                        exp[i], (i == exp.size() - 1), seq_exp[0]);
            end
         end
         checks++;
         if (lat != 0 || anom != 0) begin
            errors++; $display("FAIL basic_timing w=%h got lat=%0d anom=%0d want 0/0", w, lat, anom);
         end
         checks++;
         if (tvalid[0] !== 1'b0 || s_ready[0] !== 1'b1) begin
            errors++; $display("FAIL basic_idle got v=%b rdy=%b want 0/1", tvalid[0], s_ready[0]);
         end
         seq_exp[0]++;
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp[$]; logic [7:0] bq[$]; bit lq[$]; logic [11:0] uq[$];
      logic [15:0] w; bit e; int lat, anom;
      for (int n = 0; n < 6; n++) begin
         w = (n == 0) ? 16'hBEEF : 16'($urandom);
         e = (n == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
         drive_packet(0, w, e, 1'b1, bq, lq, uq, lat, anom);
         model(w, e, 1'b1, 1'b1, exp);
         checks++;
         if (bq.size() != exp.size()) begin
            errors++; $display("FAIL bp_len w=%h got %0d want %0d", w, bq.size(), exp.size());
         end
         for (int i = 0; i < exp.size() && i < bq.size(); i++) begin
            checks++;
            if (bq[i] !== exp[i] || lq[i] !== (i == exp.size() - 1) || uq[i] !== 12'(seq_exp[0])) begin
               errors++;
               $display("FAIL bp_byte[%0d] w=%h got %h/%b/%0d want %h/%b/%0d", i, w, bq[i], lq[i], uq[i],
                        exp[i], (i == exp.size() - 1), seq_exp[0]);
            end
         end
         checks++;
         if (lat != 0 || anom != 0) begin
            errors++; $display("FAIL bp_stability w=%h got lat=%0d anom=%0d want 0/0", w, lat, anom);
         end
         seq_exp[0]++;
      end
   endtask

   task automatic test_variants();
      logic [7:0] exp[$]; logic [7:0] bq[$]; bit lq[$]; logic [11:0] uq[$];
      logic [15:0] w; bit e; int lat, anom;
      for (int s = 1; s < 3; s++) begin
         for (int n = 0; n < 4; n++) begin
            w = (n == 0) ? 16'h00FF : 16'($urandom);
            e = (n == 3);
            drive_packet(s, w, e, 1'b0, bq, lq, uq, lat, anom);
            model(w, e, s != 1, s != 2, exp);
            checks++;
            if (bq.size() != exp.size()) begin
               errors++; $display("FAIL var_len dut%0d w=%h got %0d want %0d", s, w, bq.size(), exp.size());
            end
            for (int i = 0; i < exp.size() && i < bq.size(); i++) begin
               checks++;
               if (bq[i] !== exp[i] || lq[i] !== (i == exp.size() - 1) || uq[i] !== 12'(seq_exp[s])) begin
                  errors++;
                  $display("FAIL var_byte[%0d] dut%0d w=%h got %h/%b/%0d want %h/%b/%0d", i, s, w, bq[i], lq[i],
                           uq[i], exp[i], (i == exp.size() - 1), seq_exp[s]);
               end
            end
            checks++;
            if (lat != 0 || anom != 0) begin
               errors++; $display("FAIL var_timing dut%0d got lat=%0d anom=%0d want 0/0", s, lat, anom);
            end
            seq_exp[s]++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q[$]; logic [7:0] m[$];
      int sent, got_pk, cyc, byte_err, user_err, gap_err, gap;
      bit seen_last, hs;
      sent = 0; got_pk = 0; cyc = 0; byte_err = 0; user_err = 0; gap_err = 0; gap = 0;
      seen_last = 0; hs = 0;
      @(negedge clk); arst_n = 1'b0;
      @(negedge clk); arst_n = 1'b1;
      seq_exp = '{0, 0, 0};
      @(negedge clk);
      tready = 1'b1; s_data = 16'($urandom); s_err = ($urandom_range(0, 7) == 0); s_valid[0] = 1'b1;
      while (got_pk < 4098 && cyc < 40000) begin
         if (tvalid[0]) begin
            if (seen_last && gap != 1) gap_err++;
            seen_last = 0;
            if (exp_q.size() == 0) byte_err++;
            else if (exp_q.pop_front() !== tdata[0]) byte_err++;
            if (tuser[0] !== 12'(got_pk)) user_err++;
            if (tlast[0]) begin got_pk++; seen_last = 1; gap = 0; end
         end else if (seen_last) begin
            gap++;
         end
         hs = s_valid[0] && s_ready[0];
         if (hs) begin
            model(s_data, s_err, 1'b1, 1'b1, m);
            foreach (m[i]) exp_q.push_back(m[i]);
            sent++;
         end
         @(negedge clk);
         cyc++;
         if (hs) begin
            if (sent == 4098) s_valid[0] = 1'b0;
            else begin s_data = 16'($urandom); s_err = ($urandom_range(0, 7) == 0); end
         end
      end
      s_valid[0] = 1'b0;
      checks++;
      if (got_pk != 4098 || sent != 4098) begin
         errors++; $display("FAIL b2b_count got pk=%0d sent=%0d want 4098/4098", got_pk, sent);
      end
      checks++;
      if (byte_err != 0 || exp_q.size() != 0) begin
         errors++; $display("FAIL b2b_scoreboard got err=%0d left=%0d want 0/0", byte_err, exp_q.size());
      end
      checks++;
      if (user_err != 0) begin
         errors++; $display("FAIL b2b_tuser_wrap got %0d bad bytes want 0", user_err);
      end
      checks++;
      if (gap_err != 0) begin
         errors++; $display("FAIL b2b_gap got %0d bad gaps want 0", gap_err);
      end
      seq_exp[0] = 4098 % 4096;
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp[$]; logic [7:0] bq[$]; bit lq[$]; logic [11:0] uq[$];
      int lat, anom;
      @(negedge clk);
      tready = 1'b1; s_data = 16'h1A2F; s_err = 1'b0; s_valid[0] = 1'b1;
      @(negedge clk);
      s_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (tvalid[0] !== 1'b1 || tdata[0] !== 8'h32 || tuser[0] !== 12'(seq_exp[0])) begin
         errors++; $display("FAIL rstmid_pre got v=%b d=%h u=%0d want 1/32/%0d", tvalid[0], tdata[0], tuser[0], seq_exp[0]);
      end
      arst_n = 1'b0;
      #1;
      checks++;
      if (tvalid[0] !== 1'b0 || tlast[0] !== 1'b0 || tuser[0] !== 12'h000 || s_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_async got v=%b l=%b u=%h rdy=%b want 0/0/000/1", tvalid[0], tlast[0], tuser[0], s_ready[0]);
      end
      @(negedge clk); arst_n = 1'b1;
      seq_exp = '{0, 0, 0};
      @(negedge clk);
      checks++;
      if (s_ready[0] !== 1'b1 || tvalid[0] !== 1'b0) begin
         errors++; $display("FAIL rstmid_release got rdy=%b v=%b want 1/0", s_ready[0], tvalid[0]);
      end
      drive_packet(0, 16'h0001, 1'b0, 1'b0, bq, lq, uq, lat, anom);
      model(16'h0001, 1'b0, 1'b1, 1'b1, exp);
      checks++;
      if (bq.size() != exp.size()) begin
         errors++; $display("FAIL rstmid_len got %0d want %0d", bq.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < bq.size(); i++) begin
         checks++;
         if (bq[i] !== exp[i] || lq[i] !== (i == exp.size() - 1) || uq[i] !== 12'h000) begin
            errors++;
            $display("FAIL rstmid_byte[%0d] got %h/%b/%0d want %h/%b/0", i, bq[i], lq[i], uq[i], exp[i], (i == exp.size() - 1));
         end
      end
      checks++;
      if (lat != 0 || anom != 0) begin
         errors++; $display("FAIL rstmid_timing got lat=%0d anom=%0d want 0/0", lat, anom);
      end
   endtask

   initial begin
      arst_n = 1'b0; s_valid = '0; s_data = '0; s_err = 1'b0; tready = 1'b1;
      repeat (3) @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_variants();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_hex_tx.md
Name: alu_hex_tx

Overview:
- Transmit-side formatter for the ALU datapath.
- Accepts one binary result word per handshake and serialises it as an AXI-stream packet of ASCII hex characters, most-significant nibble first, with an optional CR LF terminator.
- Sits between the ALU result path and the UART/byte-stream transmitter.
- tlast marks the final byte of each packet; tuser carries a 12-bit packet sequence number.

Parameters:
- DATA_WIDTH, 16, result word width; must be a multiple of 4 and between 4 and 64.
- INCLUDE_CRLF, 1, 1 = append 0x0D 0x0A after the hex digits; 0 = no terminator.
- UPPERCASE, 1, 1 = hex letters 'A'-'F' (0x41-0x46); 0 = 'a'-'f' (0x61-0x66).
- AXI_WIDTH, 8, output byte width; fixed at 8, any other value is a synthesis-time error.

Ports:
- aclk_i  input  1  clock for all logic.
- arst_ni  input  1  asynchronous active-low reset.
- s_valid_i  input  1  result word valid.
- s_ready_o  output  1  block can accept a word.
- s_data_i  input  DATA_WIDTH  result word.
- s_err_i  input  1  ALU error flag, sampled with s_data_i.
- m_axis_tvalid_o  output  1  output byte valid.
- m_axis_tdata_o  output  8  ASCII byte.
- m_axis_tlast_o  output  1  last byte of packet.
- m_axis_tuser_o  output  12  packet sequence number, constant across a packet.
- m_axis_tready_i  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync release):
  - m_axis_tvalid_o=0, m_axis_tdata_o=0, m_axis_tlast_o=0, m_axis_tuser_o=0.
  - s_ready_o=1; state=IDLE; sequence counter=0.
- All outputs are registered. No combinational path from m_axis_tready_i to s_ready_o.
- States:
  - IDLE: s_ready_o=1. On s_valid_i&&s_ready_o, capture s_data_i and s_err_i. Go to ERR if s_err_i=1, else HEX. Drive s_ready_o=0 and tvalid=1 next cycle.
  - HEX: emit nibble index N-1 down to 0, where N=DATA_WIDTH/4. Digit 0-9 maps to 0x30-0x39; 10-15 maps per UPPERCASE.
  - ERR: emit 'E','R','R' (0x45 0x52 0x52) regardless of data.
  - CR then LF: emitted only when INCLUDE_CRLF=1.
  - On the last byte: tlast=1. When it is accepted, return to IDLE, raise s_ready_o, and increment the sequence counter.
- Last byte of a packet:
  - INCLUDE_CRLF=1: LF.
  - INCLUDE_CRLF=0: final hex digit, or the final 'R' for an error packet.
- Latency: input handshake at cycle T puts the first byte on the bus at T+1.
- Throughput: one byte per cycle while tready=1. There is a one-cycle IDLE bubble between packets: s_ready_o is high for at least one cycle after the last-byte handshake.
- AXI rule: while tvalid=1 and tready=0, tdata, tlast and tuser hold stable and tvalid stays high. An output byte advances only on tvalid&&tready.
- Packet lengths:
  - Hex packet: N (+2 with CRLF).
  - Error packet: 3 (+2 with CRLF).
- Sequence counter: 12-bit, wraps 4095 to 0. It is loaded into tuser at packet start and held for the whole packet.
- s_valid_i asserted while s_ready_o=0 is ignored. The upstream must hold data until handshake.
- Reset mid-packet aborts immediately: no tlast is emitted, the counter clears, and the next packet starts at tuser=0.

Decomposition:
- Package alu_tx_pkg:
  - state enum (IDLE, HEX, ERR, CR, LF).
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_E=8'h45, ASCII_R=8'h52.
  - function nibble_to_ascii(nibble, uppercase).
- Optional combinational sub-module hex_nibble_enc (4-bit to 8-bit ASCII, UPPERCASE parameter). The top-level FSM and output register stay in alu_hex_tx.

Test Plan:
- Basic packet (DATA_WIDTH=16, CRLF=1, UPPERCASE=1, tready=1): send 0x1A2F -> bytes 0x31 0x41 0x32 0x46 0x0D 0x0A on consecutive cycles starting T+1; tlast only on 0x0A; tuser=0.
- Backpressure: send 0xBEEF, toggle tready 1,0,0,1,0,1… -> bytes 0x42 0x45 0x45 0x46 0x0D 0x0A unchanged and held stable during stalls; tvalid never drops mid-packet; s_ready_o=0 throughout.
- Error, then variants:
  - s_err_i=1 with data 0x1234 -> 0x45 0x52 0x52 0x0D 0x0A with tlast on 0x0A.
  - UPPERCASE=0 with 0x00ff -> 0x30 0x30 0x66 0x66 ...
  - CRLF=0 with 0x00ff -> tlast on the second 0x66/0x46, packet length 4.
- Back-to-back and sequence wrap:
  - Hold s_valid_i high for 4098 words -> tuser runs 0..4095, 0, 1.
  - Exactly one idle cycle between packets.
  - No byte lost or duplicated (scoreboard).
- Reset mid-packet: assert arst_ni low after the second byte of 0x1A2F -> tvalid=0 in the same cycle (async). After release: s_ready_o=1; the next word 0x0001 emits 0x30 0x30 0x30 0x31 0x0D 0x0A with tuser=0.
